spi_host: RTL and testbench
===========================

# spi_host

Byte-parallel SPI host that drives the on-chip SPI responder's command bus from a simple request/response interface. Each accepted request becomes a framed byte sequence on `mosi`:

- READ: `0x03`, addr
- WRITE: `0x02`, addr, data
- STREAM: `0x80`, data

For reads, the host captures the returned byte from `miso`. It sits between the test/control logic and the responder, and is the initiator for pattern-memory loads, result readback and stream injection.

## Interface
Parameters:
- IDLE_BYTE, 8'h00: filler driven on `mosi` when no frame is active; must not equal any command code.

Ports:
- sclk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- s_req_valid  input  1  request present
- s_req_ready  output  1  request accepted when valid && ready
- s_req_op  input  2  0 = READ, 1 = WRITE, 2 = STREAM, 3 = reserved
- s_req_addr  input  5  bit4 selects result register (READ only); bits3:0 select byte 0-15
- s_req_data  input  8  write/stream payload
- m_rsp_valid  output  1  one-cycle pulse: read data or error available
- m_rsp_data  output  8  captured read byte
- m_rsp_err  output  1  qualifies `m_rsp_valid`: request rejected
- cs  output  1  high for every cycle a frame byte is on `mosi`
- mosi  output  8  byte bus to responder
- miso  input  8  byte bus from responder
- busy  output  1  state != IDLE

## Operation
- All outputs are registered. Reset values: `s_req_ready` 1, `m_rsp_valid` 0, `m_rsp_data` 0x00, `m_rsp_err` 0, `cs` 0, `mosi` IDLE_BYTE, `busy` 0.
- States: IDLE, CMD, ADDR, DATA, RD_WAIT.
- `s_req_ready` equals (state == IDLE). Request fields are latched on acceptance; they are ignored afterwards.
- IDLE, on accept:
  - op 0/1: drive `mosi` = 0x03 or 0x02, `cs` = 1, go to CMD.
  - op 2: drive `mosi` = 0x80, `cs` = 1, go to CMD.
  - op 3: no bus activity; pulse `m_rsp_valid` with `m_rsp_err` = 1; stay in IDLE.
- CMD:
  - READ/WRITE: drive `{3'b000, addr}`, go to ADDR. Bit4 is forced to 0 for WRITE.
  - STREAM: drive data, go to DATA.
- ADDR:
  - READ: drive IDLE_BYTE, keep `cs` = 1, go to RD_WAIT.
  - WRITE: drive data, go to DATA.
- DATA: drive IDLE_BYTE, `cs` = 0, go to IDLE.
- RD_WAIT: capture `miso` into `m_rsp_data`, pulse `m_rsp_valid` (`m_rsp_err` = 0), `cs` = 0, go to IDLE.
- `m_rsp_data` holds its value until the next read capture.
- Reset asserted in any state: next edge forces all reset values. Any partial frame is abandoned; the responder shares `rst_n` and also returns to idle.

## Timing
Edge E1 is the accept edge.

- READ:
  - `mosi` cmd after E1, addr after E2.
  - Responder loads `miso` at E3.
  - Host captures at E4; `m_rsp_valid` is high E4-E5.
  - `s_req_ready` returns at E4, so the next accept is at E5.
- WRITE:
  - cmd E1, addr E2, data E3, IDLE_BYTE from E4.
  - Next accept at E5.
- STREAM:
  - cmd E1, data E2, IDLE_BYTE from E3.
  - Responder's stream output is valid after E3.
  - Next accept at E4.
- Reserved op: error pulse after E1; next accept at E2.
- At least one IDLE_BYTE cycle always separates frames, so the responder never sees a payload byte as a command.
- `m_rsp_valid` never asserts on two consecutive edges for the same request.

## Configuration
- `SPI_HOST_STREAM_EN` defined: op 2 behaves as above.
- Not defined: op 2 is handled like op 3 (error pulse, no frame). The STREAM path and the 0x80 constant are not synthesized.

## Structure
- Shared package `spi_pkg`:
  - command constants CMD_READ = 8'h03, CMD_WRITE = 8'h02, CMD_STREAM = 8'h80
  - op encoding constants
  - 3-bit state encoding
  - ADDR_RESULT_BIT = 4
- The responder uses the same command constants from `spi_pkg`.
- Single module; no sub-module. The frame sequencer is small enough to stay flat.

## Test plan
- WRITE addr 5, data 0xA7 -> `mosi` sequence 0x02, 0x05, 0xA7, 0x00; `cs` high for 3 cycles; responder byte 5 = 0xA7.
- WRITE addr 5 = 0xA7, then READ addr 5 -> `mosi` 0x03, 0x05, 0x00; `m_rsp_valid` pulse at E4 with `m_rsp_data` = 0xA7, `m_rsp_err` = 0.
- READ addr 0x10 with responder result = 0x3C -> `m_rsp_data` = 0x3C.
- STREAM data 0x5A with macro defined -> `mosi` 0x80, 0x5A; responder stream output valid with data 0x5A after E3. Without macro -> no `cs`, single error pulse.
- Op 3, then back-to-back WRITEs with `s_req_valid` held -> error pulse; accepts exactly every 4 cycles; IDLE_BYTE gap between frames.
- `rst_n` low at the cycle the addr byte is driven during a READ -> next cycle `cs` = 0, `mosi` = 0x00, `s_req_ready` = 1, no `m_rsp_valid`.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI command-bus definitions: command codes, request op encoding, host state encoding.
// Used by both the host and the on-chip responder so both ends agree on framing.
// No logic; constants and types only.
package spi_pkg;

    // Command bytes that open a frame on mosi
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_STREAM = 8'h80;

    // Request op encoding on s_req_op
    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_STREAM = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    // Address bit that selects the result register instead of a byte slot (reads only)
    localparam int ADDR_RESULT_BIT = 4;

    // Host frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DATA    = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_t;

endpackage

// File: rtl/spi_host.sv
// Byte-parallel SPI host: turns READ/WRITE/STREAM requests into framed bytes on mosi, returns read data.
// Latency: READ response 4 edges after accept; WRITE frees at +4, STREAM at +3, rejected op pulses error at +1.
// Backpressure: s_req_ready low for the whole frame; one request in flight. Optional STREAM op: SPI_HOST_STREAM_EN.
module spi_host
    import spi_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       s_req_valid,
    output logic       s_req_ready,
    input  logic [1:0] s_req_op,
    input  logic [4:0] s_req_addr,
    input  logic [7:0] s_req_data,
    output logic       m_rsp_valid,
    output logic [7:0] m_rsp_data,
    output logic       m_rsp_err,
    output logic       cs,
    output logic [7:0] mosi,
    input  logic [7:0] miso,
    output logic       busy
);

    state_t     state;
    state_t     state_nxt;

    // Request fields held for the duration of the frame
    logic [1:0] op_q;
    logic [4:0] addr_q;
    logic [7:0] data_q;

    // Next values of the registered outputs
    logic       rsp_valid_nxt;
    logic       rsp_err_nxt;
    logic [7:0] rsp_data_nxt;
    logic       cs_nxt;
    logic [7:0] mosi_nxt;

    logic       accept;
    logic [4:0] addr_byte;

    assign accept = s_req_valid && s_req_ready;

    // The result-register select only has meaning for reads; writes always target a byte slot
    assign addr_byte = {addr_q[ADDR_RESULT_BIT] & (op_q == OP_READ), addr_q[3:0]};

    // State register
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture request fields on accept; they are ignored for the rest of the frame
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            op_q   <= OP_READ;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= s_req_op;
            addr_q <= s_req_addr;
            data_q <= s_req_data;
        end
    end

    // Next-state and next-output decode; every frame ends with cs low and IDLE_BYTE on the bus
    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_data_nxt  = m_rsp_data;
        cs_nxt        = 1'b0;
        mosi_nxt      = IDLE_BYTE;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (s_req_op)
                        OP_READ: begin
                            mosi_nxt  = CMD_READ;
                            cs_nxt    = 1'b1;
                            state_nxt = ST_CMD;
                        end
                        OP_WRITE: begin
                            mosi_nxt  = CMD_WRITE;
                            cs_nxt    = 1'b1;
                            state_nxt = ST_CMD;
                        end
`ifdef SPI_HOST_STREAM_EN
                        OP_STREAM: begin
                            mosi_nxt  = CMD_STREAM;
                            cs_nxt    = 1'b1;
                            state_nxt = ST_CMD;
                        end
`endif
                        default: begin
                            // Rejected op: no bus activity, single error pulse
                            rsp_valid_nxt = 1'b1;
                            rsp_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            ST_CMD: begin
                case (op_q)
                    OP_READ, OP_WRITE: begin
                        mosi_nxt  = {3'b000, addr_byte};
                        cs_nxt    = 1'b1;
                        state_nxt = ST_ADDR;
                    end
`ifdef SPI_HOST_STREAM_EN
                    OP_STREAM: begin
                        mosi_nxt  = data_q;
                        cs_nxt    = 1'b1;
                        state_nxt = ST_DATA;
                    end
`endif
                    default: begin
                        state_nxt = ST_IDLE;
                    end
                endcase
            end
            ST_ADDR: begin
                cs_nxt = 1'b1;
                if (op_q == OP_READ) begin
                    // Turnaround byte while the responder loads miso
                    mosi_nxt  = IDLE_BYTE;
                    state_nxt = ST_RD_WAIT;
                end else begin
                    mosi_nxt  = data_q;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                state_nxt = ST_IDLE;
            end
            ST_RD_WAIT: begin
                rsp_data_nxt  = miso;
                rsp_valid_nxt = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs; ready/busy derive from the state being entered so they line up with it
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            s_req_ready <= 1'b1;
            busy        <= 1'b0;
            m_rsp_valid <= 1'b0;
            m_rsp_err   <= 1'b0;
            m_rsp_data  <= 8'h00;
            cs          <= 1'b0;
            mosi        <= IDLE_BYTE;
        end else begin
            s_req_ready <= (state_nxt == ST_IDLE);
            busy        <= (state_nxt != ST_IDLE);
            m_rsp_valid <= rsp_valid_nxt;
            m_rsp_err   <= rsp_err_nxt;
            m_rsp_data  <= rsp_data_nxt;
            cs          <= cs_nxt;
            mosi        <= mosi_nxt;
        end
    end

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: responder model on the byte bus, scoreboard of expected frame bytes and responses.
// Expected bytes/responses are pushed when a request is accepted and popped as the DUT produces them.
// Build with +define+SPI_HOST_STREAM_EN to exercise the STREAM op.
module tb_spi_host;
    import spi_pkg::*;

    localparam logic [7:0] IDLE_BYTE  = 8'h00;
    localparam logic [7:0] RESULT_VAL = 8'h3C;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic       s_req_valid;
    logic       s_req_ready;
    logic [1:0] s_req_op;
    logic [4:0] s_req_addr;
    logic [7:0] s_req_data;
    logic       m_rsp_valid;
    logic [7:0] m_rsp_data;
    logic       m_rsp_err;
    logic       cs;
    logic [7:0] mosi;
    logic [7:0] miso;
    logic       busy;

    spi_host #(.IDLE_BYTE(IDLE_BYTE)) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_op    (s_req_op),
        .s_req_addr  (s_req_addr),
        .s_req_data  (s_req_data),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_data  (m_rsp_data),
        .m_rsp_err   (m_rsp_err),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .busy        (busy)
    );

    always #5 sclk = ~sclk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- responder model ----------------
    logic [7:0] resp_mem [16];
    logic [1:0] r_idx;
    logic [7:0] r_cmd;
    logic [3:0] r_addr;
    logic       stream_vld;
    logic [7:0] stream_dat;
    int         stream_cnt;

    always @(posedge sclk) begin
        if (!rst_n) begin
            r_idx      <= 2'd0;
            r_cmd      <= 8'h00;
            r_addr     <= 4'h0;
            miso       <= 8'h00;
            stream_vld <= 1'b0;
            stream_dat <= 8'h00;
            stream_cnt <= 0;
            for (int i = 0; i < 16; i++) resp_mem[i] <= 8'h00;
        end else begin
            stream_vld <= 1'b0;
            if (cs) begin
                if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd0) begin
                    r_cmd <= mosi;
                end else if (r_idx == 2'd1) begin
                    if (r_cmd == CMD_READ)
                        miso <= mosi[4] ? RESULT_VAL : resp_mem[mosi[3:0]];
                    else if (r_cmd == CMD_WRITE)
                        r_addr <= mosi[3:0];
                    else if (r_cmd == CMD_STREAM) begin
                        stream_vld <= 1'b1;
                        stream_dat <= mosi;
                        stream_cnt <= stream_cnt + 1;
                    end
                end else if (r_idx == 2'd2 && r_cmd == CMD_WRITE) begin
                    resp_mem[r_addr] <= mosi;
                end
            end else begin
                r_idx <= 2'd0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       err;
        logic [7:0] data;
        int         due;
        logic       has_data;
    } rsp_t;

    rsp_t       rsp_q [$];
    logic [7:0] mosi_q [$];
    int         len_q [$];
    int         acc_q [$];
    logic [7:0] ref_mem [16];
    int         run = 0;
    logic       mon_en = 1'b0;

    task automatic push_err(input int due);
        rsp_t r;
        r.err = 1'b1; r.data = 8'h00; r.due = due; r.has_data = 1'b0;
        rsp_q.push_back(r);
    endtask

    always @(negedge sclk) begin
        if (mon_en) begin
            // frame bytes and gaps
            if (cs) begin
                run++;
                if (mosi_q.size() == 0) chk("mosi_unexpected_cs", 32'(cs), 32'(0));
                else chk("mosi_byte", 32'(mosi), 32'(mosi_q.pop_front()));
            end else begin
                chk("mosi_idle", 32'(mosi), 32'(IDLE_BYTE));
                if (run != 0) begin
                    if (len_q.size() == 0) chk("cs_len_unexpected", 32'(run), 32'(0));
                    else chk("cs_len", 32'(run), 32'(len_q.pop_front()));
                    run = 0;
                end
            end
            chk("busy_vs_ready", 32'(busy), 32'(!s_req_ready));

            // responses
            if (m_rsp_valid) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(m_rsp_valid), 32'(0));
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(r.due));
                    chk("rsp_err", 32'(m_rsp_err), 32'(r.err));
                    if (r.has_data) chk("rsp_data", 32'(m_rsp_data), 32'(r.data));
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                chk("rsp_missing", 32'(m_rsp_valid), 32'(1));
                void'(rsp_q.pop_front());
            end

            // accepts: record what the bench drove
            if (rst_n && s_req_valid && s_req_ready) begin
                rsp_t r;
                acc_q.push_back(cyc + 1);
                case (s_req_op)
                    OP_READ: begin
                        mosi_q.push_back(CMD_READ);
                        mosi_q.push_back({3'b000, s_req_addr});
                        mosi_q.push_back(IDLE_BYTE);
                        len_q.push_back(3);
                        r.err = 1'b0; r.due = cyc + 4; r.has_data = 1'b1;
                        r.data = s_req_addr[4] ? RESULT_VAL : ref_mem[s_req_addr[3:0]];
                        rsp_q.push_back(r);
                    end
                    OP_WRITE: begin
                        mosi_q.push_back(CMD_WRITE);
                        mosi_q.push_back({4'b0000, s_req_addr[3:0]});
                        mosi_q.push_back(s_req_data);
                        len_q.push_back(3);
                        ref_mem[s_req_addr[3:0]] = s_req_data;
                    end
`ifdef SPI_HOST_STREAM_EN
                    OP_STREAM: begin
                        mosi_q.push_back(CMD_STREAM);
                        mosi_q.push_back(s_req_data);
                        len_q.push_back(2);
                    end
`endif
                    default: push_err(cyc + 1);
                endcase
            end

            // reset abandons everything in flight
            if (!rst_n) begin
                rsp_q.delete();
                mosi_q.delete();
                len_q.delete();
                run = 0;
                for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
        logic ok;
        @(posedge sclk); #1;
        s_req_valid = 1'b1; s_req_op = op; s_req_addr = a; s_req_data = d;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            if (s_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("req_accept_timeout", 32'(s_req_ready), 32'(1));
        @(posedge sclk); #1;
        s_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            if (!busy && rsp_q.size() == 0 && mosi_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("idle_timeout", 32'(busy) + 32'(rsp_q.size()) + 32'(mosi_q.size()), 32'(0));
        repeat (2) @(negedge sclk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; s_req_valid = 1'b0; s_req_op = OP_READ; s_req_addr = '0; s_req_data = '0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        chk("rst_ready", 32'(s_req_ready), 32'(1));
        chk("rst_rsp_valid", 32'(m_rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(m_rsp_data), 32'(8'h00));
        chk("rst_rsp_err", 32'(m_rsp_err), 32'(0));
        chk("rst_cs", 32'(cs), 32'(0));
        chk("rst_mosi", 32'(mosi), 32'(IDLE_BYTE));
        chk("rst_busy", 32'(busy), 32'(0));
        @(posedge sclk); #1;
        rst_n = 1'b1; mon_en = 1'b1;

        // write then read back, then result register
        req(OP_WRITE, 5'd5, 8'hA7); wait_idle();
        chk("resp_mem5", 32'(resp_mem[5]), 32'(8'hA7));
        req(OP_READ, 5'd5, 8'h00); wait_idle();
        req(OP_READ, 5'h10, 8'h00); wait_idle();
        // bit4 on a write must not leak onto the bus (addr byte forced to 0x0E)
        req(OP_WRITE, 5'h1E, 8'hC3); wait_idle();
        chk("resp_mem14", 32'(resp_mem[14]), 32'(8'hC3));

        // stream
        req(OP_STREAM, 5'd0, 8'h5A); wait_idle();
`ifdef SPI_HOST_STREAM_EN
        chk("stream_cnt", 32'(stream_cnt), 32'(1));
        chk("stream_dat", 32'(stream_dat), 32'(8'h5A));
`else
        chk("stream_cnt", 32'(stream_cnt), 32'(0));
`endif

        // reserved op, then back-to-back writes with valid held
        req(OP_RSVD, 5'd3, 8'hFF);
        acc_q.delete();
        @(posedge sclk); #1;
        s_req_valid = 1'b1; s_req_op = OP_WRITE;
        for (int k = 0; k < 4; k++) begin
            logic ok;
            s_req_addr = 5'(k + 1); s_req_data = 8'(8'h11 * (k + 1));
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge sclk);
                if (s_req_ready) begin ok = 1'b1; break; end
            end
            if (!ok) chk("b2b_accept_timeout", 32'(s_req_ready), 32'(1));
            @(posedge sclk); #1;
        end
        s_req_valid = 1'b0;
        wait_idle();
        chk("b2b_accepts", 32'(acc_q.size()), 32'(4));
        for (int k = 0; k + 1 < acc_q.size(); k++)
            chk("b2b_spacing", 32'(acc_q[k + 1] - acc_q[k]), 32'(4));
        for (int k = 1; k <= 4; k++) begin
            req(OP_READ, 5'(k), 8'h00); wait_idle();
        end

        // a few random reads/writes across the byte slots and result register
        for (int k = 0; k < 8; k++) begin
            req(($urandom_range(0, 1) == 0) ? OP_READ : OP_WRITE,
                5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            wait_idle();
        end

        // reset while the address byte of a READ is on the bus
        @(posedge sclk); #1;
        s_req_valid = 1'b1; s_req_op = OP_READ; s_req_addr = 5'd5; s_req_data = 8'h00;
        @(negedge sclk);
        chk("rstmid_ready_pre", 32'(s_req_ready), 32'(1));
        @(posedge sclk); #1;                 // E1
        s_req_valid = 1'b0;
        @(posedge sclk); #1;                 // E2: addr byte now on mosi
        chk("rstmid_addr_cs", 32'(cs), 32'(1));
        rst_n = 1'b0;
        @(posedge sclk);                     // E3 samples reset
        @(negedge sclk);
        chk("rstmid_cs", 32'(cs), 32'(0));
        chk("rstmid_mosi", 32'(mosi), 32'(IDLE_BYTE));
        chk("rstmid_ready", 32'(s_req_ready), 32'(1));
        chk("rstmid_rsp_valid", 32'(m_rsp_valid), 32'(0));
        @(posedge sclk); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge sclk);
        req(OP_WRITE, 5'd9, 8'h66); wait_idle();
        req(OP_READ, 5'd9, 8'h00); wait_idle();

        chk("left_mosi", 32'(mosi_q.size()), 32'(0));
        chk("left_rsp", 32'(rsp_q.size()), 32'(0));
        chk("left_len", 32'(len_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // hard stop if the stimulus itself stalls
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
